// File: rtl/fifo_uart_tx.sv
// Pulls one byte at a time from an upstream FIFO and sends it as an 8N1 UART frame.
// Ren, TxD and Busy are registered and change together with the state.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       Fempty,
   input  logic [7:0] Fdata,
   output logic       Ren,
   output logic       TxD,
   output logic       Busy
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned BIT_W = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [BIT_W-1:0] bitcnt;
   logic [7:0]       shreg;
   logic             bit_done;

   assign bit_done = (cnt == CNT_LAST);

   // Outputs are assigned on the same edge as the state they belong to.
   always_ff @(posedge ck) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         Ren    <= 1'b0;
         TxD    <= 1'b1;
         Busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!Fempty) begin
                  state <= REQ;
                  Ren   <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            REQ: begin
               state <= LOAD;
               Ren   <= 1'b0;
            end
            LOAD: begin
               shreg <= Fdata;
               cnt   <= '0;
               state <= START;
               TxD   <= 1'b0;
            end
            START: begin
               if (bit_done) begin
                  cnt    <= '0;
                  bitcnt <= '0;
                  state  <= DATA;
                  TxD    <= shreg[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt   <= '0;
                  shreg <= shreg >> 1;
                  if (bitcnt == BIT_LAST) begin
                     state <= STOP;
                     TxD   <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + BIT_W'(1);
                     TxD    <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_done) begin
                  cnt   <= '0;
                  state <= IDLE;
                  Busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               Ren   <= 1'b0;
               TxD   <= 1'b1;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds the DUT, a line monitor decodes frames,
// and expected frames queued at enqueue time are compared against decoded ones.
module tb_fifo_uart_tx;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit i = i-th transmitted bit (start first, stop last)
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fempty = 1'b1;
   logic [7:0] fdata = 8'h00;
   logic       ren, txd, busy;

   logic       fempty2 = 1'b1;
   logic [7:0] fdata2 = 8'h00;
   logic       ren2, txd2, busy2;

   int checks = 0;
   int failures = 0;

   // FIFO model state (tb writes wr_ptr/mem, model block reads/advances rd_ptr)
   logic [7:0] fifo_mem [64];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       hold = 1'b0;
   logic       scramble = 1'b0;

   // line monitor state
   int         cyc = 0;
   int         ren_cnt = 0;
   int         ren_at [64];
   int         busy_run = 0;
   int         last_busy_run = 0;
   logic       in_frame = 1'b0;
   int         k = 0;
   logic [39:0] samp;
   int         frames_done = 0;
   logic [9:0] got_frame [64];
   logic       got_unstable [64];
   int         next_got = 0;

   logic [9:0] exp_q [$];
   vec_t       tbl [7];

   fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut (
      .ck(clk), .rst(rst), .Fempty(fempty), .Fdata(fdata),
      .Ren(ren), .TxD(txd), .Busy(busy)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
      .ck(clk), .rst(rst), .Fempty(fempty2), .Fdata(fdata2),
      .Ren(ren2), .TxD(txd2), .Busy(busy2)
   );

   always #5 clk = ~clk;

   // FIFO model and line monitor for u_dut, all on the falling edge
   always @(negedge clk) begin
      logic [9:0] fr;
      logic       uns;
      cyc++;
      if (ren) begin
         if (rd_ptr != wr_ptr) begin
            fdata = fifo_mem[rd_ptr & 63];
            rd_ptr++;
         end
         hold = 1'b1;
      end else if (hold) begin
         hold = 1'b0;
      end else if (scramble) begin
         fdata = 8'($urandom);
      end
      if (scramble && busy) fempty = 1'($urandom);
      else                  fempty = (rd_ptr == wr_ptr);

      if (ren) begin
         if (ren_cnt < 64) ren_at[ren_cnt] = cyc;
         ren_cnt++;
      end
      if (busy) busy_run++;
      else begin
         if (busy_run != 0) last_busy_run = busy_run;
         busy_run = 0;
      end

      if (!rst) begin
         in_frame = 1'b0;
      end else if (in_frame) begin
         samp[k] = txd;
         k++;
         if (k == 40) begin
            fr  = '0;
            uns = 1'b0;
            for (int b = 0; b < 10; b++) begin
               fr[b] = samp[4*b];
               for (int s = 1; s < 4; s++)
                  if (samp[4*b+s] != samp[4*b]) uns = 1'b1;
            end
            got_frame[frames_done & 63]    = fr;
            got_unstable[frames_done & 63] = uns;
            frames_done++;
            in_frame = 1'b0;
         end
      end else if (busy && !txd) begin
         in_frame = 1'b1;
         samp[0]  = txd;
         k        = 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic enqueue(input int i);
      fifo_mem[wr_ptr & 63] = tbl[i].data;
      wr_ptr++;
      exp_q.push_back(tbl[i].frame);
   endtask

   task automatic wait_frames(input int target, input string name);
      int n = 0;
      while (frames_done < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, 32'(frames_done >= target), 32'd1);
   endtask

   task automatic compare_frame(input string name);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(got_frame[next_got & 63]), 32'(e));
         check({name, "_timing"}, 32'(got_unstable[next_got & 63]), 32'd0);
      end
      next_got++;
   endtask

   initial begin
      int viol;
      int base;
      int n;
      int nb;
      logic [21:0] s2;

      tbl[0] = '{8'hA5, 10'b1_10100101_0};
      tbl[1] = '{8'h00, 10'b1_00000000_0};
      tbl[2] = '{8'hFF, 10'b1_11111111_0};
      tbl[3] = '{8'h3C, 10'b1_00111100_0};
      tbl[4] = '{8'h5A, 10'b1_01011010_0};
      tbl[5] = '{8'h01, 10'b1_00000001_0};
      tbl[6] = '{8'hC3, 10'b1_11000011_0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_ren", 32'(ren), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
      rst = 1'b1;

      // empty FIFO: line stays idle
      viol = 0;
      repeat (100) begin
         @(negedge clk);
         if (ren || !txd || busy) viol++;
      end
      check("idle_hold", 32'(viol), 32'd0);
      check("idle_ren_cnt", 32'(ren_cnt), 32'd0);

      // single 0xA5 frame
      @(posedge clk); #1;
      enqueue(0);
      wait_frames(1, "a5_done");
      compare_frame("a5_frame");
      repeat (3) @(posedge clk);
      #1;
      check("a5_busy_len", 32'(last_busy_run), 32'd42);
      check("a5_ren_cnt", 32'(ren_cnt), 32'd1);

      // table vectors one at a time
      for (int i = 1; i < 7; i++) begin
         @(posedge clk); #1;
         base = ren_cnt;
         enqueue(i);
         wait_frames(frames_done + 1, "tbl_done");
         compare_frame($sformatf("tbl_frame_%0d", i));
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("tbl_ren_%0d", i), 32'(ren_cnt - base), 32'd1);
         check($sformatf("tbl_busy_%0d", i), 32'(last_busy_run), 32'd42);
      end

      // back-to-back 0x00, 0xFF, 0x3C
      @(posedge clk); #1;
      base = ren_cnt;
      enqueue(1); enqueue(2); enqueue(3);
      wait_frames(frames_done + 3, "b2b_done");
      compare_frame("b2b_0");
      compare_frame("b2b_1");
      compare_frame("b2b_2");
      repeat (3) @(posedge clk);
      #1;
      check("b2b_ren_cnt", 32'(ren_cnt - base), 32'd3);
      check("b2b_gap_01", 32'(ren_at[base+1] - ren_at[base]), 32'd43);
      check("b2b_gap_12", 32'(ren_at[base+2] - ren_at[base+1]), 32'd43);

      // reset while transmitting data bit 3
      @(posedge clk); #1;
      nb = frames_done;
      enqueue(4);
      n = 0;
      while (!(in_frame && k >= 17) && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("abort_reached_bit3", 32'(n < 200), 32'd1);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_txd", 32'(txd), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ren", 32'(ren), 32'd0);
      rst = 1'b1;
      void'(exp_q.pop_front());
      repeat (50) @(posedge clk);
      #1;
      check("abort_no_frame", 32'(frames_done), 32'(nb));
      check("abort_stays_idle", 32'(busy), 32'd0);
      base = ren_cnt;
      enqueue(5);
      wait_frames(nb + 1, "fresh_done");
      compare_frame("fresh_frame");
      repeat (3) @(posedge clk);
      #1;
      check("fresh_ren_cnt", 32'(ren_cnt - base), 32'd1);
      check("fresh_busy_len", 32'(last_busy_run), 32'd42);

      // Fempty/Fdata noise while frames are in flight
      @(posedge clk); #1;
      base = ren_cnt;
      scramble = 1'b1;
      enqueue(6); enqueue(4);
      wait_frames(frames_done + 2, "noise_done");
      repeat (3) @(posedge clk);
      #1;
      scramble = 1'b0;
      compare_frame("noise_0");
      compare_frame("noise_1");
      check("noise_ren_cnt", 32'(ren_cnt - base), 32'd2);

      // CLKS_PER_BIT=2, byte 0x80
      @(posedge clk); #1;
      fdata2  = 8'h80;
      fempty2 = 1'b0;
      s2 = '0;
      n  = 0;
      base = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (ren2) begin
            base++;
            fempty2 = 1'b1;
         end
         if (busy2) begin
            if (n < 22) s2[n] = txd2;
            n++;
         end
      end
      check("cpb2_busy_len", 32'(n), 32'd22);
      check("cpb2_ren_cnt", 32'(base), 32'd1);
      check("cpb2_wave", 32'(s2), 32'h3C0003);
      check("cpb2_idle_txd", 32'(txd2), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The module SHALL take parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit, legal range 2..65535.
REQ-002 The module SHALL have port ck, input, 1 bit, system clock; all state updates on posedge ck.
REQ-003 The module SHALL have port rst, input, 1 bit; reset rst is synchronous and active-low.
REQ-004 The module SHALL have port Fempty, input, 1 bit, empty flag of the upstream 16x8 FIFO.
REQ-005 The module SHALL have port Fdata, input, 8 bits, FIFO read data, valid the cycle after a Ren cycle.
REQ-006 The module SHALL have port Ren, output, 1 bit, FIFO read strobe.
REQ-007 The module SHALL have port TxD, output, 1 bit, serial line, idle high.
REQ-008 The module SHALL have port Busy, output, 1 bit, high whenever a fetch or frame is in progress.

Function
REQ-009 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA, STOP; Busy = (state != IDLE).
REQ-010 IDLE: TxD=1, Ren=0; if Fempty==0 at a posedge, next state REQ; otherwise remain in IDLE.
REQ-011 REQ: Ren=1 for exactly one cycle, unconditionally; next state LOAD.
REQ-012 LOAD: Ren=0, TxD=1; at the posedge ending LOAD, Fdata is captured into an 8-bit shift register; next state START.
REQ-013 START: TxD=0 for CLKS_PER_BIT cycles; next state DATA.
REQ-014 DATA: TxD = shift register bit 0 for CLKS_PER_BIT cycles per bit; shift right after each bit; 8 bits, LSB first; a 3-bit bit counter selects STOP after bit 7.
REQ-015 STOP: TxD=1 for CLKS_PER_BIT cycles; next state IDLE.
REQ-016 Bit timing SHALL use a 16-bit down/up counter cleared on each state or bit change; it terminates at CLKS_PER_BIT-1 with no drift.
REQ-017 Frame length, from entering REQ to re-entering IDLE, SHALL be 2 + 10*CLKS_PER_BIT cycles.
REQ-018 Ren SHALL be a registered output: never asserted outside REQ, and never more than once per frame.
REQ-019 Fempty SHALL be ignored in every state except IDLE; a Fempty change mid-frame SHALL NOT alter the frame.
REQ-020 Back-to-back operation: if Fempty==0 on the cycle after STOP completes (IDLE), REQ SHALL follow immediately, giving a minimum 1 idle-high cycle between frames.
REQ-021 Fdata SHALL be sampled only at the end of LOAD; Fdata changes at other times SHALL have no effect.

Reset
REQ-022 When rst==0 at a posedge: state=IDLE, TxD=1, Ren=0, Busy=0, counters and shift register cleared.
REQ-023 Reset mid-frame SHALL abort the frame; TxD=1 from the next cycle, with no partial-frame completion.
REQ-024 After a mid-frame reset, a byte already popped from the FIFO SHALL be discarded.
REQ-025 rst has priority over all other inputs.

Verification
REQ-026 Reset, then Fempty=1 held for 100 cycles -> Ren never 1, TxD constant 1, Busy 0.
REQ-027 CLKS_PER_BIT=4, one byte 0xA5 available -> Ren pulses exactly once; TxD is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Busy is high for 42 cycles.
REQ-028 Three bytes 0x00, 0xFF, 0x3C queued -> three Ren pulses spaced 43 cycles apart; frames decode to 0x00, 0xFF, 0x3C in order; exactly 1 idle-high cycle between frames.
REQ-029 rst=0 asserted in DATA at bit 3 -> next cycle TxD=1, Busy=0, Ren=0; later Fempty=0 -> a fresh full frame starts, beginning with REQ.
REQ-030 Fempty toggled and Fdata randomized during START/DATA/STOP -> transmitted bits equal the byte captured at LOAD; no extra Ren pulse.
REQ-031 CLKS_PER_BIT=2 edge case, byte 0x80 -> frame length 22 cycles; bit 7 (1) is the last data bit before the stop bit.
